// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction-fetch stage between the PC unit and decode. Each accepted
//   fetch address is forwarded to instruction memory and allocated an entry
//   in an in-order queue; in-order memory responses fill those entries, and
//   the oldest filled entry is presented to decode as {id_pc, id_instr}.
//   A flush empties the queue and remembers how many memory responses are
//   still owed, so they are discarded when they eventually arrive.
//
// Ports
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   pc_in/pc_valid    fetch address from the PC unit
//   pc_ready          fetch accepts pc_in this cycle
//   imem_req_valid    memory request valid (address = pc_in)
//   imem_req_ready    memory accepts the request
//   imem_req_addr     request address
//   imem_rsp_valid    in-order response, at most one per cycle, no backpressure
//   imem_rsp_data     fetched instruction
//   flush             redirect: drop all queued and in-flight fetches
//   id_valid/id_ready handshake to decode
//   id_pc, id_instr   delivered address/instruction pair (0 when not valid)
module if_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_instr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   ONE     = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W+1:0] DEPTH_V = DEPTH[PTR_W+1:0];

    logic [ADDR_W-1:0] pc_q    [DEPTH];
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [DEPTH-1:0]  filled;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   head, tail, rsp, drop_cnt;
    logic [PTR_W:0]   occ, unfilled, owed;
    logic [PTR_W+1:0] budget;
    logic [PTR_W-1:0] head_idx, tail_idx, rsp_idx;
    logic             credit, alloc, fill, drop, pop;

    assign head_idx = head[PTR_W-1:0];
    assign tail_idx = tail[PTR_W-1:0];
    assign rsp_idx  = rsp[PTR_W-1:0];

    assign occ      = tail - head;
    assign unfilled = tail - rsp;
    // Responses still owed by memory at a flush: stale ones plus live ones.
    assign owed     = drop_cnt + unfilled;

    // Entries promised to stale responses still consume credit, otherwise a
    // late stale response could land on top of a fresh allocation.
    assign budget = {1'b0, occ} + {1'b0, drop_cnt};
    assign credit = budget < DEPTH_V;

    assign imem_req_valid = pc_valid & credit & ~flush;
    assign pc_ready       = imem_req_ready & credit & ~flush;
    assign imem_req_addr  = pc_in;

    assign alloc = pc_valid & pc_ready;
    assign drop  = imem_rsp_valid & (drop_cnt != '0);
    assign fill  = imem_rsp_valid & (drop_cnt == '0) & (unfilled != '0);

    assign id_valid = filled[head_idx] & (occ != '0) & ~flush;
    assign id_pc    = id_valid ? pc_q[head_idx]    : '0;
    assign id_instr = id_valid ? instr_q[head_idx] : '0;
    assign pop      = id_valid & id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            rsp      <= '0;
            drop_cnt <= '0;
            filled   <= '0;
        end else if (flush) begin
            head   <= '0;
            tail   <= '0;
            rsp    <= '0;
            filled <= '0;
            // A response arriving in the flush cycle is one of the owed ones
            // and is consumed here; the guard only matters for an orphan
            // response, which must not wrap the counter.
            if (imem_rsp_valid && (owed != '0)) begin
                drop_cnt <= owed - ONE;
            end else begin
                drop_cnt <= owed;
            end
        end else begin
            // alloc/fill/pop can never address the same slot in one cycle,
            // so the three filled[] updates are independent.
            if (alloc) begin
                filled[tail_idx] <= 1'b0;
                tail             <= tail + ONE;
            end
            if (fill) begin
                filled[rsp_idx] <= 1'b1;
                rsp             <= rsp + ONE;
            end
            if (pop) begin
                filled[head_idx] <= 1'b0;
                head             <= head + ONE;
            end
            if (drop) begin
                drop_cnt <= drop_cnt - ONE;
            end
        end
    end

    // Payload storage needs no reset: filled[] qualifies every read.
    always_ff @(posedge clk) begin
        if (alloc) begin
            pc_q[tail_idx] <= pc_in;
        end
        if (fill) begin
            instr_q[rsp_idx] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue
//   Bench for if_fetch_queue. The bench plays the PC unit, the instruction
//   memory (in-order, programmable 1+ cycle latency) and decode. A reference
//   model keeps the list of live fetches awaiting delivery and the list of
//   requests the memory still owes, each tagged live / dropped / orphan.
//
// Ports: none (top-level bench).
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    if_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_in          (pc_in),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    // kind: 0 live, 1 dropped by flush, 2 orphaned by reset
    typedef struct {
        logic [31:0] addr;
        int          kind;
    } mem_t;

    mem_t        mem_pend[$];
    logic [31:0] deliv[$];
    int          got_cnt = 0;
    bit          rsp_en  = 1'b0;
    bit          last_alloc = 1'b0;
    int          n_issued = 0;
    int          n_popped = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;

    logic        obs_id_valid, obs_pc_ready, obs_req_valid;
    logic [31:0] obs_id_pc, obs_id_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_0013;
    endfunction

    function automatic int dropped_pending();
        int n = 0;
        foreach (mem_pend[i]) if (mem_pend[i].kind == 1) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit pv, input logic [31:0] pc, input bit re,
                          input bit fl, input bit ir);
        pc_valid       = pv;
        pc_in          = pc;
        imem_req_ready = 1'b1;
        rsp_en         = re;
        flush          = fl;
        id_ready       = ir;
    endtask

    // One clock: memory drives its response, outputs are checked mid-cycle
    // against the model, then the model advances with the edge.
    task automatic cycle();
        bit rv, credit, e_prdy, e_rqv, e_idv, alloc, pop;
        int kind;
        mem_t m;
        rv = rsp_en && (mem_pend.size() != 0);
        imem_rsp_valid = rv;
        imem_rsp_data  = '0;
        if (rv) imem_rsp_data = mem_word(mem_pend[0].addr);
        @(negedge clk);
        credit = (deliv.size() + dropped_pending()) < DEPTH;
        e_prdy = imem_req_ready && credit && !flush;
        e_rqv  = pc_valid && credit && !flush;
        e_idv  = (got_cnt > 0) && !flush;
        chk("pc_ready", {63'd0, pc_ready}, {63'd0, e_prdy});
        chk("imem_req_valid", {63'd0, imem_req_valid}, {63'd0, e_rqv});
        chk("imem_req_addr", {32'd0, imem_req_addr}, {32'd0, pc_in});
        chk("id_valid", {63'd0, id_valid}, {63'd0, e_idv});
        if (e_idv) begin
            chk("id_pc", {32'd0, id_pc}, {32'd0, deliv[0]});
            chk("id_instr", {32'd0, id_instr}, {32'd0, mem_word(deliv[0])});
        end else begin
            chk("id_pc_idle", {32'd0, id_pc}, 64'd0);
            chk("id_instr_idle", {32'd0, id_instr}, 64'd0);
        end
        obs_id_valid  = id_valid;
        obs_id_pc     = id_pc;
        obs_id_instr  = id_instr;
        obs_pc_ready  = pc_ready;
        obs_req_valid = imem_req_valid;
        alloc = pc_valid && e_prdy;
        pop   = e_idv && id_ready;
        if (flush) begin
            if (rv) void'(mem_pend.pop_front());
            foreach (mem_pend[i]) if (mem_pend[i].kind == 0) mem_pend[i].kind = 1;
            deliv.delete();
            got_cnt = 0;
        end else begin
            if (rv) begin
                kind = mem_pend[0].kind;
                void'(mem_pend.pop_front());
                if (kind == 0) got_cnt++;
            end
            if (pop) begin
                void'(deliv.pop_front());
                got_cnt--;
                n_popped++;
            end
            if (alloc) begin
                deliv.push_back(pc_in);
                m.addr = pc_in;
                m.kind = 0;
                mem_pend.push_back(m);
                n_issued++;
            end
        end
        last_alloc = alloc;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        while ((deliv.size() != 0 || mem_pend.size() != 0) && n < 100) begin
            cycle();
            n++;
        end
        chk(tag, 64'(deliv.size() + mem_pend.size()), 64'd0);
    endtask

    initial begin
        int cyc;
        int popped0;
        int issued0;
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
        chk("rst_id_pc", {32'd0, id_pc}, 64'd0);
        chk("rst_id_instr", {32'd0, id_instr}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming with a 1-cycle memory: four back-to-back deliveries.
        for (int i = 0; i < 6; i++) begin
            set_in(i < 4, 32'(i * 4), 1'b1, 1'b0, 1'b1);
            cycle();
            if (i >= 2) begin
                chk("t2_valid", {63'd0, obs_id_valid}, 64'd1);
                chk("t2_pc", {32'd0, obs_id_pc}, 64'((i - 2) * 4));
                chk("t2_instr", {32'd0, obs_id_instr}, {32'd0, mem_word(32'((i - 2) * 4))});
            end
        end
        drain("t2_drain");

        // Full queue with decode stalled, then one pop releases a slot.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h40 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
            cycle();
        end
        set_in(1'b1, 32'h50, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("t3_full_pc_ready", {63'd0, obs_pc_ready}, 64'd0);
        chk("t3_full_req_valid", {63'd0, obs_req_valid}, 64'd0);
        set_in(1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
        cycle();
        chk("t3_pop_cycle_pc_ready", {63'd0, obs_pc_ready}, 64'd0);
        set_in(1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("t3_after_pop_pc_ready", {63'd0, obs_pc_ready}, 64'd1);
        drain("t3_drain");

        // Flush with one filled entry and two fetches in flight.
        set_in(1'b1, 32'h60, 1'b1, 1'b0, 1'b0); cycle();
        set_in(1'b1, 32'h64, 1'b1, 1'b0, 1'b0); cycle();
        set_in(1'b1, 32'h68, 1'b0, 1'b0, 1'b0); cycle();
        set_in(1'b0, 32'h0,  1'b0, 1'b1, 1'b0); cycle();
        chk("t4_flush_id_valid", {63'd0, obs_id_valid}, 64'd0);
        set_in(1'b0, 32'h0,  1'b0, 1'b0, 1'b1); cycle();
        chk("t4_empty_id_valid", {63'd0, obs_id_valid}, 64'd0);
        set_in(1'b0, 32'h0,   1'b1, 1'b0, 1'b1); cycle();
        set_in(1'b0, 32'h0,   1'b1, 1'b0, 1'b1); cycle();
        set_in(1'b1, 32'h100, 1'b1, 1'b0, 1'b1); cycle();
        set_in(1'b0, 32'h0,   1'b1, 1'b0, 1'b1); cycle();
        set_in(1'b0, 32'h0,   1'b1, 1'b0, 1'b1); cycle();
        chk("t4_redirect_valid", {63'd0, obs_id_valid}, 64'd1);
        chk("t4_redirect_pc", {32'd0, obs_id_pc}, 64'h100);
        drain("t4_drain");

        // Flush coinciding with a response: only the other in-flight one is owed.
        set_in(1'b1, 32'h80, 1'b0, 1'b0, 1'b0); cycle();
        set_in(1'b1, 32'h84, 1'b0, 1'b0, 1'b0); cycle();
        set_in(1'b0, 32'h0,  1'b1, 1'b1, 1'b0); cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        set_in(1'b1, 32'h20C, 1'b0, 1'b0, 1'b0); cycle();
        chk("t5_owed_blocks", {63'd0, obs_pc_ready}, 64'd0);
        set_in(1'b1, 32'h20C, 1'b1, 1'b0, 1'b0); cycle();
        set_in(1'b1, 32'h20C, 1'b0, 1'b0, 1'b0); cycle();
        chk("t5_after_drop", {63'd0, obs_pc_ready}, 64'd1);
        drain("t5_drain");

        // Reset mid-stream: two filled, one in flight.
        set_in(1'b1, 32'h10, 1'b0, 1'b0, 1'b0); cycle();
        set_in(1'b1, 32'h14, 1'b1, 1'b0, 1'b0); cycle();
        set_in(1'b1, 32'h18, 1'b1, 1'b0, 1'b0); cycle();
        set_in(1'b0, 32'h0,  1'b0, 1'b0, 1'b0); cycle();
        chk("t1_pre_valid", {63'd0, obs_id_valid}, 64'd1);
        imem_rsp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_id_valid", {63'd0, id_valid}, 64'd0);
        chk("t1_rst_id_pc", {32'd0, id_pc}, 64'd0);
        deliv.delete();
        got_cnt = 0;
        foreach (mem_pend[i]) mem_pend[i].kind = 2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // The orphaned response arrives; the emptied queue must ignore it.
        set_in(1'b0, 32'h0,  1'b1, 1'b0, 1'b1); cycle();
        chk("t1_orphan_ignored", {63'd0, obs_id_valid}, 64'd0);
        set_in(1'b1, 32'h20, 1'b1, 1'b0, 1'b1); cycle();
        set_in(1'b0, 32'h0,  1'b1, 1'b0, 1'b1); cycle();
        set_in(1'b0, 32'h0,  1'b1, 1'b0, 1'b1); cycle();
        chk("t1_restart_pc", {32'd0, obs_id_pc}, 64'h20);
        drain("t1_drain");

        // Random traffic: variable memory latency, random stalls on both sides.
        popped0 = n_popped;
        issued0 = n_issued;
        cyc = 0;
        pc_in = $urandom & 32'hFFFF_FFFC;
        while ((n_issued - issued0) < 200 && cyc < 5000) begin
            pc_valid       = ($urandom % 4) != 0;
            imem_req_ready = ($urandom % 4) != 0;
            rsp_en         = ($urandom % 3) != 0;
            id_ready       = ($urandom % 2) != 0;
            flush          = 1'b0;
            cycle();
            if (last_alloc) pc_in = $urandom & 32'hFFFF_FFFC;
            cyc++;
        end
        chk("t6_issued", 64'(n_issued - issued0), 64'd200);
        drain("t6_drain");
        chk("t6_delivered", 64'(n_popped - popped0), 64'd200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
